// File: rtl/zoom_pkg.sv
// Shared types for the zoom sequencer: level/code table, FSM states,
// pending-request bundle and control_data field offsets.
package zoom_pkg;

    localparam logic [2:0] LVL_MIN = 3'd0;
    localparam logic [2:0] LVL_MAX = 3'd4;

    localparam int CD_W        = 10;
    localparam int CD_ZOOM_LSB = 7;
    localparam int CD_ALG_LSB  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        DIR_RECOMP,
        DIR_IN,
        DIR_OUT
    } dir_e;

    typedef struct packed {
        dir_e dir;
        logic valid;
    } pend_t;

    function automatic logic [2:0] zoom_code_of(input logic [2:0] lvl);
        logic [2:0] code;
        case (lvl)
            3'd0:    code = 3'b100;
            3'd1:    code = 3'b011;
            3'd2:    code = 3'b000;
            3'd3:    code = 3'b001;
            3'd4:    code = 3'b010;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/zoom_level_ctrl.sv
// Zoom level bookkeeping: resolves request pulses, keeps the 1-entry
// pending request and the committed level, applies saturation.
module zoom_level_ctrl
    import zoom_pkg::*;
#(
    parameter logic [2:0] DEFAULT_LEVEL = 3'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zoom_in_req,
    input  logic       zoom_out_req,
    input  logic       recompute_req,
    input  logic       i_hold,
    input  logic       i_take,
    output logic       o_accept,
    output logic [2:0] o_target_code
);

    logic [2:0] r_level;
    pend_t      r_pend;

    pend_t      w_new;
    pend_t      w_req;
    logic       w_sat;
    logic [2:0] w_target;

    always_comb begin
        w_new.valid = (zoom_in_req ^ zoom_out_req) | recompute_req;
        w_new.dir   = DIR_RECOMP;
        if (zoom_in_req & ~zoom_out_req) begin
            w_new.dir = DIR_IN;
        end else if (zoom_out_req & ~zoom_in_req) begin
            w_new.dir = DIR_OUT;
        end
    end

    // A fresh pulse is newer than anything parked while busy.
    assign w_req = w_new.valid ? w_new : r_pend;

    always_comb begin
        w_sat    = 1'b0;
        w_target = r_level;
        unique case (w_req.dir)
            DIR_IN: begin
                w_sat    = (r_level == LVL_MAX);
                w_target = r_level + 3'd1;
            end
            DIR_OUT: begin
                w_sat    = (r_level == LVL_MIN);
                w_target = r_level - 3'd1;
            end
            default: begin
                w_sat    = 1'b0;
                w_target = r_level;
            end
        endcase
    end

    assign o_accept      = i_take & w_req.valid & ~w_sat;
    assign o_target_code = zoom_code_of(w_target);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= DEFAULT_LEVEL;
            r_pend  <= '0;
        end else begin
            if (o_accept) begin
                r_level <= w_target;
            end
            if (i_take) begin
                r_pend <= '0;
            end else if (i_hold && w_new.valid) begin
                r_pend <= w_new;
            end
        end
    end

endmodule

// File: rtl/zoom_sequencer.sv
// Zoom coprocessor sequencer: commits the target zoom level, then
// resets, launches and monitors alu_algoritmos.
module zoom_sequencer
    import zoom_pkg::*;
#(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20,
    parameter int DEFAULT_LEVEL  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            zoom_in_req,
    input  logic            zoom_out_req,
    input  logic            recompute_req,
    input  logic [3:0]      alg_sel,
    input  logic            alu_done,
    output logic            alu_reset,
    output logic            alu_start,
    output logic [CD_W-1:0] control_data,
    output logic [2:0]      prop_zoom,
    output logic            busy,
    output logic            frame_valid,
    output logic            error
);

    localparam logic [2:0]       DEF_LVL  = 3'(DEFAULT_LEVEL);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_alu_reset;
    logic              r_alu_start;
    logic [CD_W-1:0]   r_ctrl;
    logic [2:0]        r_prop;
    logic              r_busy;
    logic              r_fv;
    logic              r_err;

    logic              w_take;
    logic              w_hold;
    logic              w_accept;
    logic [2:0]        w_target_code;

    assign w_take = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_hold = (r_state == S_CLEAR) || (r_state == S_LAUNCH)
                 || (r_state == S_RUN);

    zoom_level_ctrl #(
        .DEFAULT_LEVEL (DEF_LVL)
    ) u_level (
        .clock         (clock),
        .reset         (reset),
        .zoom_in_req   (zoom_in_req),
        .zoom_out_req  (zoom_out_req),
        .recompute_req (recompute_req),
        .i_hold        (w_hold),
        .i_take        (w_take),
        .o_accept      (w_accept),
        .o_target_code (w_target_code)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_alu_reset <= 1'b1;
            r_alu_start <= 1'b0;
            r_ctrl      <= '0;
            r_prop      <= zoom_code_of(DEF_LVL);
            r_busy      <= 1'b1;
            r_fv        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prop <= w_target_code;
                r_fv   <= 1'b0;
                r_err  <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_state     <= S_CLEAR;
                        r_alu_reset <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == RST_LAST) begin
                        // control word goes out together with the start pulse
                        r_state     <= S_LAUNCH;
                        r_cnt       <= '0;
                        r_alu_reset <= 1'b0;
                        r_alu_start <= 1'b1;
                        r_ctrl      <= '0;
                        r_ctrl[CD_ZOOM_LSB +: 3] <= r_prop;
                        r_ctrl[CD_ALG_LSB +: 4]  <= alg_sel;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_state     <= S_RUN;
                    r_cnt       <= '0;
                    r_alu_start <= 1'b0;
                end
                S_RUN: begin
                    if (alu_done) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_fv    <= 1'b1;
                    end else if (r_cnt == TO_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_state     <= S_CLEAR;
                        r_alu_reset <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_reset    = r_alu_reset;
    assign alu_start    = r_alu_start;
    assign control_data = r_ctrl;
    assign prop_zoom    = r_prop;
    assign busy         = r_busy;
    assign frame_valid  = r_fv;
    assign error        = r_err;

endmodule

// File: tb/tb_zoom_sequencer.sv
// Directed bench for zoom_sequencer: table of zoom requests from idle
// plus hand-written pending, timeout and mid-run reset sequences.
module tb_zoom_sequencer;

    localparam int RST_CYC = 4;
    localparam int TO_CYC  = 1000;

    logic       clock;
    logic       reset;
    logic       zoom_in_req;
    logic       zoom_out_req;
    logic       recompute_req;
    logic [3:0] alg_sel;
    logic       alu_done;
    logic       alu_reset;
    logic       alu_start;
    logic [9:0] control_data;
    logic [2:0] prop_zoom;
    logic       busy;
    logic       frame_valid;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    zoom_sequencer #(
        .RESET_CYCLES   (RST_CYC),
        .TIMEOUT_CYCLES (TO_CYC),
        .CNT_W          (20),
        .DEFAULT_LEVEL  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .zoom_in_req   (zoom_in_req),
        .zoom_out_req  (zoom_out_req),
        .recompute_req (recompute_req),
        .alg_sel       (alg_sel),
        .alu_done      (alu_done),
        .alu_reset     (alu_reset),
        .alu_start     (alu_start),
        .control_data  (control_data),
        .prop_zoom     (prop_zoom),
        .busy          (busy),
        .frame_valid   (frame_valid),
        .error         (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       zin;
        logic       zout;
        logic       rec;
        logic [3:0] alg;
        logic       starts;
        logic [2:0] code;
    } vec_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic zin, input logic zout, input logic rec);
        zoom_in_req   = zin;
        zoom_out_req  = zout;
        recompute_req = rec;
        step();
        zoom_in_req   = 1'b0;
        zoom_out_req  = 1'b0;
        recompute_req = 1'b0;
    endtask

    // Entered on the first CLEAR cycle; leaves on the first RUN cycle.
    task automatic expect_launch(input logic [2:0] code, input logic [3:0] alg);
        for (int k = 0; k < RST_CYC; k++) begin
            chk("clear_rst_start", 32'({alu_reset, alu_start}), 32'(2'b10));
            step();
        end
        chk("launch_rst_start", 32'({alu_reset, alu_start}), 32'(2'b01));
        chk("launch_ctrl", 32'(control_data), 32'({code, alg, 3'b000}));
        step();
        chk("run_start_low", 32'(alu_start), 32'(0));
        chk("run_busy", 32'(busy), 32'(1));
    endtask

    task automatic finish_frame(input logic [2:0] code);
        repeat (20) step();
        chk("run_no_fv", 32'(frame_valid), 32'(0));
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("done_fv", 32'(frame_valid), 32'(1));
        chk("done_prop", 32'(prop_zoom), 32'(code));
        chk("done_busy", 32'(busy), 32'(1));
        step();
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_fv", 32'(frame_valid), 32'(1));
    endtask

    task automatic expect_quiet(input logic [2:0] code);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | alu_start | alu_reset | busy;
            step();
        end
        chk("quiet_no_seq", 32'(seen), 32'(0));
        chk("quiet_prop", 32'(prop_zoom), 32'(code));
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 3'b001};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 3'b010};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 3'b010};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 3'b001};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 3'b000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 3'b011};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 3'b100};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 3'b100};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 3'b100};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b1, 3'b100};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 3'b011};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 3'b011};

        reset         = 1'b1;
        zoom_in_req   = 1'b0;
        zoom_out_req  = 1'b0;
        recompute_req = 1'b0;
        alu_done      = 1'b0;
        alg_sel       = 4'h5;
        repeat (3) step();
        chk("rst_alu_reset", 32'(alu_reset), 32'(1));
        chk("rst_alu_start", 32'(alu_start), 32'(0));
        chk("rst_ctrl", 32'(control_data), 32'(0));
        chk("rst_prop", 32'(prop_zoom), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_fv", 32'(frame_valid), 32'(0));
        chk("rst_err", 32'(error), 32'(0));
        reset = 1'b0;
        expect_launch(3'b000, 4'h5);
        repeat (79) step();
        finish_frame(3'b000);

        for (int i = 0; i < 12; i++) begin
            alg_sel = vecs[i].alg;
            pulse(vecs[i].zin, vecs[i].zout, vecs[i].rec);
            if (vecs[i].starts) begin
                chk("vec_accept_prop", 32'(prop_zoom), 32'(vecs[i].code));
                chk("vec_accept_fv", 32'(frame_valid), 32'(0));
                expect_launch(vecs[i].code, vecs[i].alg);
                finish_frame(vecs[i].code);
            end else begin
                expect_quiet(vecs[i].code);
            end
        end

        // in then out while running: only the later step survives
        alg_sel = 4'h1;
        pulse(1'b1, 1'b0, 1'b0);
        expect_launch(3'b000, 4'h1);
        repeat (3) step();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("pend_done_fv", 32'(frame_valid), 32'(1));
        chk("pend_done_prop", 32'(prop_zoom), 32'(3'b000));
        step();
        chk("pend_clear_rst", 32'(alu_reset), 32'(1));
        chk("pend_clear_fv", 32'(frame_valid), 32'(0));
        chk("pend_clear_prop", 32'(prop_zoom), 32'(3'b011));
        expect_launch(3'b011, 4'h1);
        finish_frame(3'b011);
        expect_quiet(3'b011);

        // timeout with alu_done withheld
        pulse(1'b0, 1'b0, 1'b1);
        expect_launch(3'b011, 4'h1);
        repeat (TO_CYC - 1) step();
        chk("to_pre_err", 32'(error), 32'(0));
        chk("to_pre_busy", 32'(busy), 32'(1));
        step();
        chk("to_err", 32'(error), 32'(1));
        chk("to_fv", 32'(frame_valid), 32'(0));
        chk("to_busy", 32'(busy), 32'(0));
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("idle_done_ignored", 32'(busy), 32'(0));
        chk("err_sticky", 32'(error), 32'(1));
        pulse(1'b0, 1'b0, 1'b1);
        chk("err_cleared", 32'(error), 32'(0));
        expect_launch(3'b011, 4'h1);
        finish_frame(3'b011);

        // reset in the middle of a run
        pulse(1'b0, 1'b1, 1'b0);
        expect_launch(3'b100, 4'h1);
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("mid_rst_alu_reset", 32'(alu_reset), 32'(1));
        chk("mid_rst_fv", 32'(frame_valid), 32'(0));
        chk("mid_rst_prop", 32'(prop_zoom), 32'(3'b000));
        chk("mid_rst_busy", 32'(busy), 32'(1));
        chk("mid_rst_ctrl", 32'(control_data), 32'(0));
        reset = 1'b0;
        expect_launch(3'b000, 4'h1);
        finish_frame(3'b000);
        pulse(1'b1, 1'b0, 1'b0);
        expect_launch(3'b001, 4'h1);
        finish_frame(3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
